// File: rtl/fp_div_sequencer_pkg.sv
// Shared types and constants for the single-precision divide sequencer.
// Holds operand classes, FSM states, flag bit positions and special-case resolution.
package fp_pkg;

    typedef enum logic [1:0] {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN} fp_class_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_e;

    localparam int NV = 3;
    localparam int DZ = 2;
    localparam int OF = 1;
    localparam int UF = 0;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [7:0]  BIAS    = 8'd127;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flags;
        logic        use_div;
    } bypass_t;

    // First matching rule wins; use_div is set only when both operands are Normal.
    function automatic bypass_t classify_bypass(fp_class_e ca, fp_class_e cb, logic s);
        bypass_t r;
        r.res     = '0;
        r.flags   = '0;
        r.use_div = 1'b0;
        if (ca == FP_NAN || cb == FP_NAN) begin
            r.res       = QNAN;
            r.flags[NV] = 1'b1;
        end else if ((ca == FP_INF && cb == FP_INF) || (ca == FP_ZERO && cb == FP_ZERO)) begin
            r.res       = QNAN;
            r.flags[NV] = 1'b1;
        end else if (ca == FP_INF) begin
            r.res = {s, POS_INF[30:0]};
        end else if (cb == FP_INF) begin
            r.res = {s, 31'h0};
        end else if (ca == FP_ZERO) begin
            r.res = {s, 31'h0};
        end else if (cb == FP_ZERO) begin
            r.res       = {s, POS_INF[30:0]};
            r.flags[DZ] = 1'b1;
        end else begin
            r.use_div = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_div_sequencer_if.sv
// Operand and result valid/ready channels of the divide sequencer.
interface fp_div_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [3:0]  out_flags;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_flags
    );

endinterface

// File: rtl/fp_div_sequencer_classify.sv
// Combinational IEEE-754 single-precision operand classifier; denormals read as Zero.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] val_i,
    output fp_class_e   class_o,
    output logic        sign_o
);

    logic [7:0]  exp;
    logic [22:0] man;

    assign exp    = val_i[30:23];
    assign man    = val_i[22:0];
    assign sign_o = val_i[31];

    always_comb begin
        class_o = FP_NORMAL;
        if (exp == 8'hFF) begin
            class_o = (man != 23'h0) ? FP_NAN : FP_INF;
        end else if (exp == 8'h00) begin
            class_o = FP_ZERO;
        end
    end

endmodule

// File: rtl/fp_div_sequencer.sv
// Issue/retire stage in front of a combinational divider: resolves special operands
// locally, issues ordinary pairs for one cycle, and holds cleaned results for the consumer.
module fp_div_sequencer
    import fp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    fp_div_sequencer_if.slave   bus,
    output logic [31:0]         div_op_a_o,
    output logic [31:0]         div_op_b_o,
    output logic                div_en_o,
    input  logic [31:0]         div_res_i,
    input  logic                div_of_i,
    input  logic                div_uf_i,
    output logic [3:0]          sticky_flags_o,
    input  logic                clr_sticky_i,
    output logic [15:0]         op_count_o
);

    state_e      state_q, state_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    bypass_t     byp_q, byp_d;
    logic        sign_q, sign_d;
    logic [31:0] res_q, res_d;
    logic [3:0]  flags_q, flags_d;
    logic [3:0]  sticky_q, sticky_d;
    logic [15:0] count_q, count_d;

    fp_class_e   cls_a, cls_b;
    logic        sign_a, sign_b;
    logic        accept, retire;

    fp_classify u_class_a (.val_i(bus.in_a), .class_o(cls_a), .sign_o(sign_a));
    fp_classify u_class_b (.val_i(bus.in_b), .class_o(cls_b), .sign_o(sign_b));

    assign bus.in_ready  = rst_n & ((state_q == S_IDLE) | ((state_q == S_HOLD) & bus.out_ready));
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_res   = res_q;
    assign bus.out_flags = flags_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign retire = (state_q == S_HOLD) & bus.out_ready;

    assign div_op_a_o     = op_a_q;
    assign div_op_b_o     = op_b_q;
    assign div_en_o       = (state_q == S_ISSUE) & byp_q.use_div;
    assign sticky_flags_o = sticky_q;
    assign op_count_o     = count_q;

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        byp_d    = byp_q;
        sign_d   = sign_q;
        res_d    = res_q;
        flags_d  = flags_q;
        sticky_d = sticky_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_HOLD;
                flags_d = byp_q.flags;
                res_d   = byp_q.res;
                // Divider overflow outranks underflow; its own divide-by-zero is never consulted.
                if (byp_q.use_div) begin
                    flags_d = '0;
                    res_d   = div_res_i;
                    if (div_of_i) begin
                        res_d       = {sign_q, POS_INF[30:0]};
                        flags_d[OF] = 1'b1;
                    end else if (div_uf_i) begin
                        res_d       = {sign_q, 31'h0};
                        flags_d[UF] = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (bus.out_ready) state_d = bus.in_valid ? S_ISSUE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            byp_d  = classify_bypass(cls_a, cls_b, sign_a ^ sign_b);
            sign_d = sign_a ^ sign_b;
            if (byp_d.use_div) begin
                op_a_d = bus.in_a;
                op_b_d = bus.in_b;
            end
        end

        // A clear arriving with a retire keeps only the retiring flags.
        if (retire) begin
            sticky_d = clr_sticky_i ? flags_q : (sticky_q | flags_q);
            count_d  = count_q + 16'd1;
        end else if (clr_sticky_i) begin
            sticky_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            byp_q    <= '0;
            sign_q   <= 1'b0;
            res_q    <= '0;
            flags_q  <= '0;
            sticky_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            byp_q    <= byp_d;
            sign_q   <= sign_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

endmodule
